branch_cond_unit: RTL and testbench

Parametrised successor to the 4-way branch-condition mux feeding the PCWriteCond AND gate in the multi-cycle datapath. Latches ALU comparison flags, evaluates a selectable branch condition with optional inversion, and issues a registered PC-write enable one cycle after an evaluation request. Adds stale-flag detection and saturating taken/not-taken counters for debug. Sits between the ALU flag outputs, the control FSM (cond select, PCWriteCond) and the PC register write enable.

---
 rtl/branch_pkg.sv | 15 +
 rtl/branch_cond_eval.sv | 42 ++++
 rtl/branch_cond_unit.sv | 146 ++++++++++++++
 tb/tb_branch_cond_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch-condition unit: base condition indices.
package branch_pkg;

    localparam int NUM_BASE_COND = 8;

    localparam logic [2:0] COND_EQ     = 3'd0;
    localparam logic [2:0] COND_NE     = 3'd1;
    localparam logic [2:0] COND_GT     = 3'd2;
    localparam logic [2:0] COND_LE     = 3'd3;
    localparam logic [2:0] COND_LT     = 3'd4;
    localparam logic [2:0] COND_GE     = 3'd5;
    localparam logic [2:0] COND_ALWAYS = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator: flags + selector + invert -> result.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int SEL_W = 3
) (
    input  logic             zero_i,
    input  logic             gt_i,
    input  logic             lt_i,
    input  logic [SEL_W-1:0] cond_sel_i,
    input  logic             invert_i,
    output logic             result_o
);

    logic [SEL_W:0] sel_ext_s;
    logic           in_base_s;
    logic           cond_s;

    // Select the base condition; indices beyond the base map are hard false.
    always_comb begin
        sel_ext_s = {1'b0, cond_sel_i};
        in_base_s = (sel_ext_s < (SEL_W+1)'(NUM_BASE_COND));
        cond_s    = 1'b0;
        if (in_base_s) begin
            case (cond_sel_i[2:0])
                COND_EQ:     cond_s = zero_i;
                COND_NE:     cond_s = ~zero_i;
                COND_GT:     cond_s = gt_i;
                COND_LE:     cond_s = ~gt_i;
                COND_LT:     cond_s = lt_i;
                COND_GE:     cond_s = ~lt_i;
                COND_ALWAYS: cond_s = 1'b1;
                COND_NEVER:  cond_s = 1'b0;
                default:     cond_s = 1'b0;
            endcase
        end else begin
            cond_s = 1'b0;
        end
        result_o = cond_s ^ invert_i;
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch-condition unit: latches ALU flags, evaluates a selected condition and
// issues a registered PC-write enable, with stale-flag detection and statistics.
module branch_cond_unit
    import branch_pkg::*;
#(
    parameter  int NUM_COND = 8,
    parameter  int CNT_W    = 16,
    localparam int SEL_W    = $clog2(NUM_COND)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flags_load,
    input  logic             alu_zero,
    input  logic             alu_gt,
    input  logic             alu_lt,
    input  logic             eval_req,
    input  logic [SEL_W-1:0] cond_sel,
    input  logic             invert,
    input  logic             write_cond,
    input  logic             cnt_clear,
    output logic             taken_valid,
    output logic             branch_taken,
    output logic             pc_write,
    output logic             flags_stale,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] nottaken_cnt
);

    logic             zero_q, gt_q, lt_q, fresh_q;
    logic             zero_d, gt_d, lt_d, fresh_d;
    logic             valid_q, taken_q, pcw_q, stale_q;
    logic             valid_d, taken_d, pcw_d, stale_d;
    logic [CNT_W-1:0] tcnt_q, ncnt_q, tcnt_d, ncnt_d;
    logic             eff_zero_s, eff_gt_s, eff_lt_s;
    logic             result_s;

    // Same-cycle load bypasses the flag registers so the new flags are evaluated.
    always_comb begin
        if (flags_load) begin
            eff_zero_s = alu_zero;
            eff_gt_s   = alu_gt;
            eff_lt_s   = alu_lt;
        end else begin
            eff_zero_s = zero_q;
            eff_gt_s   = gt_q;
            eff_lt_s   = lt_q;
        end
    end

    branch_cond_eval #(.SEL_W(SEL_W)) u_eval (
        .zero_i     (eff_zero_s),
        .gt_i       (eff_gt_s),
        .lt_i       (eff_lt_s),
        .cond_sel_i (cond_sel),
        .invert_i   (invert),
        .result_o   (result_s)
    );

    // Next-state for flags, freshness, result pulses and saturating counters.
    always_comb begin
        zero_d  = zero_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        fresh_d = fresh_q;
        tcnt_d  = tcnt_q;
        ncnt_d  = ncnt_q;

        if (flags_load) begin
            zero_d = alu_zero;
            gt_d   = alu_gt;
            lt_d   = alu_lt;
        end else begin
            zero_d = zero_q;
        end

        // Evaluation consumes flags, including bypassed ones.
        if (eval_req) begin
            fresh_d = 1'b0;
        end else if (flags_load) begin
            fresh_d = 1'b1;
        end else begin
            fresh_d = fresh_q;
        end

        valid_d = eval_req;
        taken_d = eval_req & result_s;
        pcw_d   = eval_req & result_s & write_cond;
        stale_d = eval_req & ~fresh_q & ~flags_load;

        if (cnt_clear) begin
            tcnt_d = {CNT_W{1'b0}};
            ncnt_d = {CNT_W{1'b0}};
        end else if (eval_req && write_cond) begin
            if (result_s) begin
                if (tcnt_q != {CNT_W{1'b1}}) begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end else begin
                    tcnt_d = tcnt_q;
                end
            end else begin
                if (ncnt_q != {CNT_W{1'b1}}) begin
                    ncnt_d = ncnt_q + CNT_W'(1);
                end else begin
                    ncnt_d = ncnt_q;
                end
            end
        end else begin
            tcnt_d = tcnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            zero_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            fresh_q <= 1'b0;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            pcw_q   <= 1'b0;
            stale_q <= 1'b0;
            tcnt_q  <= {CNT_W{1'b0}};
            ncnt_q  <= {CNT_W{1'b0}};
        end else begin
            zero_q  <= zero_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            fresh_q <= fresh_d;
            valid_q <= valid_d;
            taken_q <= taken_d;
            pcw_q   <= pcw_d;
            stale_q <= stale_d;
            tcnt_q  <= tcnt_d;
            ncnt_q  <= ncnt_d;
        end
    end

    assign taken_valid  = valid_q;
    assign branch_taken = taken_q;
    assign pc_write     = pcw_q;
    assign flags_stale  = stale_q;
    assign taken_cnt    = tcnt_q;
    assign nottaken_cnt = ncnt_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Scoreboard bench for branch_cond_unit: a behavioural model predicts every cycle's
// outputs into a queue, and an independent monitor pops and compares them.
module tb_branch_cond_unit;

    localparam int NUM_COND = 16;
    localparam int CNT_W    = 2;
    localparam int SEL_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, flags_load, alu_zero, alu_gt, alu_lt;
    logic             eval_req, invert, write_cond, cnt_clear;
    logic [SEL_W-1:0] cond_sel;
    logic             taken_valid, branch_taken, pc_write, flags_stale;
    logic [CNT_W-1:0] taken_cnt, nottaken_cnt;

    typedef struct {
        bit v, t, p, s;
        int tc, nc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    // Model state
    bit m_zero, m_gt, m_lt, m_fresh;
    int m_tc, m_nc;

    always #5 clk = ~clk;

    branch_cond_unit #(.NUM_COND(NUM_COND), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flags_load(flags_load),
        .alu_zero(alu_zero), .alu_gt(alu_gt), .alu_lt(alu_lt),
        .eval_req(eval_req), .cond_sel(cond_sel), .invert(invert),
        .write_cond(write_cond), .cnt_clear(cnt_clear),
        .taken_valid(taken_valid), .branch_taken(branch_taken),
        .pc_write(pc_write), .flags_stale(flags_stale),
        .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
    );

    function automatic bit ref_cond(int sel, bit z, bit g, bit l);
        case (sel)
            0: return z;
            1: return !z;
            2: return g;
            3: return !g;
            4: return l;
            5: return !l;
            6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input bit rst_n, input bit ld, input bit z, input bit g,
                        input bit l, input bit ev, input int sel, input bit inv,
                        input bit wc, input bit clr);
        exp_t e;
        bit fz, fg, fl, res;
        @(negedge clk);
        #1;
        reset = rst_n; flags_load = ld; alu_zero = z; alu_gt = g; alu_lt = l;
        eval_req = ev; cond_sel = SEL_W'(sel); invert = inv; write_cond = wc;
        cnt_clear = clr;
        e = '{default: 0};
        if (!rst_n) begin
            m_zero = 0; m_gt = 0; m_lt = 0; m_fresh = 0; m_tc = 0; m_nc = 0;
        end else begin
            fz = ld ? z : m_zero;
            fg = ld ? g : m_gt;
            fl = ld ? l : m_lt;
            res = ref_cond(sel, fz, fg, fl) ^ inv;
            e.v = ev;
            e.t = ev && res;
            e.p = ev && res && wc;
            e.s = ev && !m_fresh && !ld;
            if (clr) begin
                m_tc = 0; m_nc = 0;
            end else if (ev && wc) begin
                if (res) m_tc = (m_tc < CNT_MAX) ? m_tc + 1 : m_tc;
                else     m_nc = (m_nc < CNT_MAX) ? m_nc + 1 : m_nc;
            end
            if (ev) m_fresh = 0;
            else if (ld) m_fresh = 1;
            if (ld) begin
                m_zero = z; m_gt = g; m_lt = l;
            end
        end
        e.tc = m_tc;
        e.nc = m_nc;
        exp_q.push_back(e);
        mon_en = 1'b1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares the DUT's visible outputs against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL scoreboard_underflow: got empty queue expected entry");
                end else begin
                    e = exp_q.pop_front();
                    chk("taken_valid",  int'(taken_valid),  int'(e.v));
                    chk("branch_taken", int'(branch_taken), int'(e.t));
                    chk("pc_write",     int'(pc_write),     int'(e.p));
                    chk("flags_stale",  int'(flags_stale),  int'(e.s));
                    chk("taken_cnt",    int'(taken_cnt),    e.tc);
                    chk("nottaken_cnt", int'(nottaken_cnt), e.nc);
                end
            end
        end
    end

    initial begin
        reset = 0; flags_load = 0; alu_zero = 0; alu_gt = 0; alu_lt = 0;
        eval_req = 0; cond_sel = '0; invert = 0; write_cond = 0; cnt_clear = 0;

        // Reset held with eval_req asserted, then idle
        step(0, 0, 0, 0, 0, 1, 6, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 6, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Load zero, then EQ with write_cond
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        // Bypass: load gt with same-cycle GT evaluation
        step(1, 1, 0, 1, 0, 1, 2, 0, 1, 0);
        // One load lt, two LT-inverted evaluations (second is stale)
        step(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 4, 1, 1, 0);
        step(1, 0, 0, 0, 0, 1, 4, 1, 1, 0);
        // Saturation of taken counter, then clear with eval
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1, 6, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 6, 0, 1, 1);
        // ALWAYS without write_cond, and out-of-map index 9
        step(1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1, 9, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 15, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, NUM_COND-1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 15) == 0));
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #2;
        mon_en = 1'b0;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
